muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide execution unit for the RV32M extension. It sits beside the single-cycle adder, logic, shift, branch, memory and CSR units in the execute stage. While an operation is in progress it freezes the pipeline through a combinational hold. It returns one registered result per accepted instruction, implementing RISC-V `M` semantics including the divide-by-zero and signed-overflow cases.

## Interface
- `XLEN`, 32: operand/result width; must be a multiple of `ITER_BITS`.
- `ITER_BITS`, 1: quotient/product bits retired per iteration cycle; legal values are 1, 2, 4.
- `MUL_ITERATIVE`, 0: 0 = multiply completes through the fast path (full-width product, 1 cycle); 1 = multiply uses the shift-add iteration, same timing as divide.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: downstream pipeline stall; freezes the DONE state.
- `flush_i` in 1: kill the current/arriving operation (branch taken or exception).
- `start_i` in 1: execute stage holds a valid M-extension instruction.
- `operation_i` in 3: funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `first_operand_i` in XLEN: rs1 value, already forwarded.
- `second_operand_i` in XLEN: rs2 value, already forwarded.
- `hold_o` out 1: combinational; pipeline must not advance while high.
- `valid_o` out 1: registered; `result_o` is valid.
- `result_o` out XLEN: registered result.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **Accept:** in IDLE with `start_i`=1 and `flush_i`=0.
  - Latch the operation.
  - Latch operand magnitudes: two's-complement negate if the operand is treated as signed and its MSB is 1. Signed treatment:
    - rs1 is signed for MULH, MULHSU, DIV, REM.
    - rs2 is signed for MULH, DIV, REM.
  - Latch the sign of the final result:
    - Quotient/product: XOR of the operand signs.
    - Remainder: dividend sign.
  - Load the iteration counter with `XLEN/ITER_BITS`.
- **Fast path (IDLE→DONE directly)** covers three cases:
  - Multiply with `MUL_ITERATIVE`=0.
  - Divisor == 0: quotient = all ones; remainder = dividend.
  - Signed overflow, DIV/REM with rs1 = 1<<(XLEN-1) and rs2 = all ones: quotient = rs1; remainder = 0.
- **Otherwise IDLE→CALC.**
  - Each CALC cycle retires `ITER_BITS` bits. Divide is restoring radix-2, repeated `ITER_BITS` times combinationally. Multiply is shift-add into a 2·XLEN accumulator.
  - The counter decrements each CALC cycle; on the cycle it reaches 1, go to FIX.
- **FIX:** apply sign negation and select the result:
  - MUL: low XLEN bits.
  - MULH, MULHSU, MULHU: high XLEN bits.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
  - FIX always goes to DONE.
- **DONE:** `valid_o`=1 and `result_o` is stable.
  - `stall`=1: remain in DONE.
  - `stall`=0: go to IDLE next edge.
  - `start_i` is ignored in DONE; it still belongs to the completed instruction.
- **`hold_o`** = (IDLE & `start_i` & !`flush_i`) | CALC | FIX. It is low in DONE, so the instruction retires that cycle.
- **Flush:** `flush_i`=1 in any state → IDLE on the next edge; `valid_o` goes to 0 and no result is produced.
  - Flush wins over a simultaneous `start_i`.
  - Flush wins over a DONE with `stall`=1.
- `start_i` outside IDLE is ignored; no re-accept or restart is possible mid-operation.

## Timing
- **Reset** (synchronous, dominant over all inputs): state = IDLE, counter = 0, `valid_o` = 0, `result_o` = 0, `hold_o` = 0 (combinationally, assuming `start_i`=0).
- **Fast path:**
  - Accept at edge 0.
  - DONE and `valid_o`=1 after edge 1.
  - Latency 1 cycle.
  - `hold_o` is high for exactly the accept cycle.
- **Iterative path,** with N = `XLEN/ITER_BITS`:
  - CALC occupies N cycles, then FIX takes 1 cycle.
  - `valid_o`=1 after edge N+2.
  - `hold_o` is high for N+2 cycles. For XLEN=32, ITER_BITS=1 that is 34 cycles; for ITER_BITS=4 it is 10 cycles.
- `valid_o` is high only in DONE; it lasts 1 cycle if `stall`=0, otherwise until `stall` falls.
- Back-to-back operations: a new `start_i` is accepted in the cycle after DONE exits, with no extra bubble.
- Reset mid-CALC discards all partial state. The first `start_i` after reset is accepted normally.

## Test plan
- **MUL and MULHU:**
  - MUL 7 × 0xFFFFFFFD (−3) → `result_o`=0xFFFFFFEB, `valid_o` 1 cycle after accept (`MUL_ITERATIVE`=0).
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - Repeat both with `MUL_ITERATIVE`=1 and check latency 34.
- **Signed divide:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD, `hold_o` high 34 cycles, `valid_o` on cycle 34.
  - REM of the same operands → 0xFFFFFFFF.
  - DIVU of the same operands → 0x7FFFFFFC.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; both in 1 cycle.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- **Flush:**
  - `flush_i` at CALC cycle 10 → IDLE next edge, `hold_o`=0, `valid_o` never rises.
  - Immediately after, DIVU 100/7 → 14 with full latency.
- **Stall:** `stall` held high for 3 cycles while in DONE → `valid_o` and `result_o` held 3 cycles, then drop 1 edge after `stall` falls.
- **Reset and parameters:**
  - `reset` mid-CALC → all outputs 0 next edge.
  - With ITER_BITS=4, DIV 1000/3 → 333 at latency 10.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle RV32M multiply/divide execution unit. Accepts one M-extension
//   instruction at a time. While it is busy it holds the pipeline through a
//   combinational hold. It returns one registered result per accepted
//   instruction.
//
//   Parameters
//     XLEN          operand/result width, a multiple of ITER_BITS
//     ITER_BITS     bits retired per CALC cycle (1, 2 or 4)
//     MUL_ITERATIVE 0: single-cycle full-width multiply, 1: shift-add multiply
//
//   Ports
//     clk, reset         clock, synchronous active-high reset
//     stall              downstream stall, keeps a finished result in DONE
//     flush_i            kills the current or arriving operation
//     start_i            valid M instruction present in execute
//     operation_i        funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//     first_operand_i    rs1
//     second_operand_i   rs2
//     hold_o             combinational pipeline hold
//     valid_o, result_o  registered result handshake
module muldiv_unit #(
   parameter int XLEN          = 32,
   parameter int ITER_BITS     = 1,
   parameter int MUL_ITERATIVE = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      operation_i,
   input  logic [XLEN-1:0] first_operand_i,
   input  logic [XLEN-1:0] second_operand_i,
   output logic            hold_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int N  = XLEN / ITER_BITS;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state, state_n;
   logic [2:0]      op_q;
   logic            res_neg;
   logic [CW-1:0]   cnt;
   // Shared datapath registers:
   //   divide:   acc_hi = partial remainder, acc_lo = dividend -> quotient, opb = divisor
   //   multiply: acc_hi = product high,      acc_lo = multiplier -> product low, opb = multiplicand
   logic [XLEN-1:0] acc_hi, acc_lo, opb;

   // ---------------- operand decode at accept ----------------
   logic              is_div, is_rem, rs1_signed, rs2_signed, s1, s2, neg_in;
   logic              div_zero, div_ovf, fast, accept;
   logic [XLEN-1:0]   mag1, mag2, fast_res;
   logic [2*XLEN-1:0] fprod, fprod_s;

   always_comb begin
      is_div     = operation_i[2];
      is_rem     = operation_i[2] & operation_i[1];
      rs1_signed = (operation_i == 3'b001) | (operation_i == 3'b010) |
                   (operation_i == 3'b100) | (operation_i == 3'b110);
      rs2_signed = (operation_i == 3'b001) | (operation_i == 3'b100) |
                   (operation_i == 3'b110);
      s1         = rs1_signed & first_operand_i[XLEN-1];
      s2         = rs2_signed & second_operand_i[XLEN-1];
      mag1       = s1 ? -first_operand_i  : first_operand_i;
      mag2       = s2 ? -second_operand_i : second_operand_i;
      // A remainder takes the dividend's sign. Quotients and products take the XOR.
      neg_in     = is_rem ? s1 : (s1 ^ s2);
      div_zero   = is_div & (second_operand_i == '0);
      // Only the signed divide ops (DIV=100, REM=110) can overflow.
      div_ovf    = is_div & ~operation_i[0] &
                   (first_operand_i == {1'b1, {(XLEN-1){1'b0}}}) &
                   (second_operand_i == '1);
      fast       = (!is_div && MUL_ITERATIVE == 0) || div_zero || div_ovf;
      accept     = (state == IDLE) & start_i & ~flush_i;

      fprod      = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
      fprod_s    = neg_in ? -fprod : fprod;

      if (div_zero)
         fast_res = operation_i[1] ? first_operand_i : '1;
      else if (div_ovf)
         fast_res = operation_i[1] ? '0 : first_operand_i;
      else if (operation_i == 3'b000)
         fast_res = fprod_s[XLEN-1:0];
      else
         fast_res = fprod_s[2*XLEN-1:XLEN];
   end

   // ---------------- one CALC cycle: ITER_BITS radix-2 steps ----------------
   logic [XLEN-1:0] hi_n, lo_n;
   logic [XLEN:0]   tmp;

   always_comb begin
      hi_n = acc_hi;
      lo_n = acc_lo;
      tmp  = '0;
      for (int i = 0; i < ITER_BITS; i++) begin
         if (op_q[2]) begin
            // Restoring divide: shift in the next dividend bit, subtract if it fits.
            tmp  = {hi_n, lo_n[XLEN-1]};
            lo_n = {lo_n[XLEN-2:0], 1'b0};
            if (tmp >= {1'b0, opb}) begin
               tmp     = tmp - {1'b0, opb};
               lo_n[0] = 1'b1;
            end
            hi_n = tmp[XLEN-1:0];
         end else begin
            // Shift-add multiply. The carry out of the add shifts down into acc_hi.
            tmp  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opb} : '0);
            lo_n = {tmp[0], lo_n[XLEN-1:1]};
            hi_n = tmp[XLEN:1];
         end
      end
   end

   // ---------------- FIX: sign correction and result select ----------------
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   q_s, r_s, fix_res;

   always_comb begin
      prod_s = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      q_s    = res_neg ? -acc_lo : acc_lo;
      r_s    = res_neg ? -acc_hi : acc_hi;
      case (op_q)
         3'b000:         fix_res = prod_s[XLEN-1:0];
         3'b001, 3'b010,
         3'b011:         fix_res = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101: fix_res = q_s;
         default:        fix_res = r_s;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      hold_o  = 1'b0;
      case (state)
         IDLE: if (accept) begin
            hold_o  = 1'b1;
            state_n = fast ? DONE : CALC;
         end
         CALC: begin
            hold_o = 1'b1;
            if (cnt == CW'(1)) state_n = FIX;
         end
         FIX: begin
            hold_o  = 1'b1;
            state_n = DONE;
         end
         DONE: if (!stall) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Flush beats a new start and a stalled DONE.
      if (flush_i) state_n = IDLE;
   end

   // ---------------- datapath and output registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q     <= '0;
         res_neg  <= 1'b0;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opb      <= '0;
         valid_o  <= 1'b0;
         result_o <= '0;
      end else begin
         valid_o <= (state_n == DONE);
         if (accept) begin
            op_q    <= operation_i;
            res_neg <= neg_in;
            cnt     <= CW'(N);
            acc_hi  <= '0;
            acc_lo  <= is_div ? mag1 : mag2;
            opb     <= is_div ? mag2 : mag1;
            if (fast) result_o <= fast_res;
         end else if (state == CALC) begin
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            cnt    <= cnt - CW'(1);
         end else if (state == FIX && !flush_i) begin
            result_o <= fix_res;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, stall, flush;
   logic [2:0]       start, hold, valid;
   logic [2:0]       op;
   logic [31:0]      a, b;
   logic [2:0][31:0] res;

   int n_chk  = 0;
   int n_pass = 0;

   // u0: fast multiply, radix-2. u1: iterative multiply, radix-2. u2: iterative, 4 bits/cycle.
   muldiv_unit #(.XLEN(32), .ITER_BITS(1), .MUL_ITERATIVE(0)) u0 (
      .clk(clk), .reset(reset), .stall(stall), .flush_i(flush), .start_i(start[0]),
      .operation_i(op), .first_operand_i(a), .second_operand_i(b),
      .hold_o(hold[0]), .valid_o(valid[0]), .result_o(res[0]));
   muldiv_unit #(.XLEN(32), .ITER_BITS(1), .MUL_ITERATIVE(1)) u1 (
      .clk(clk), .reset(reset), .stall(stall), .flush_i(flush), .start_i(start[1]),
      .operation_i(op), .first_operand_i(a), .second_operand_i(b),
      .hold_o(hold[1]), .valid_o(valid[1]), .result_o(res[1]));
   muldiv_unit #(.XLEN(32), .ITER_BITS(4), .MUL_ITERATIVE(1)) u2 (
      .clk(clk), .reset(reset), .stall(stall), .flush_i(flush), .start_i(start[2]),
      .operation_i(op), .first_operand_i(a), .second_operand_i(b),
      .hold_o(hold[2]), .valid_o(valid[2]), .result_o(res[2]));

   typedef struct {
      int          dut;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 25;
   vec_t  vecs [NV];
   string opn  [8] = '{"mul", "mulh", "mulhsu", "mulhu", "div", "divu", "rem", "remu"};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   // Called at a negedge with unit k idle. It issues one op and holds start until
   // valid is seen, the way execute keeps the instruction until it retires. It then
   // checks result, latency, hold length and the one-cycle valid pulse.
   // It returns at a negedge with the unit idle again.
   task automatic run_op(input int k, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e, input int lat_e,
                         input string name);
      int lat   = 0;
      int holds = 0;
      bit got   = 1'b0;
      op = o; a = x; b = y; start[k] = 1'b1;
      while (!got && lat < 100) begin
         #1;
         if (hold[k]) holds++;
         @(posedge clk); lat++;
         @(negedge clk); got = valid[k];
      end
      start[k] = 1'b0;
      check({name, " valid"},       {31'b0, got},  32'd1);
      check({name, " result"},      res[k],        e);
      check({name, " latency"},     32'(lat),      32'(lat_e));
      check({name, " hold cycles"}, 32'(holds),    32'(lat_e));
      @(posedge clk); @(negedge clk);
      check({name, " valid drop"},  {31'b0, valid[k]}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; start = '0;
      op = '0; a = '0; b = '0;

      vecs[0]  = '{0, 3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1};
      vecs[1]  = '{0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1};
      vecs[2]  = '{0, 3'b001, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 1};
      vecs[3]  = '{0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
      vecs[4]  = '{0, 3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34};
      vecs[5]  = '{0, 3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34};
      vecs[6]  = '{0, 3'b101, 32'hFFFFFFF9, 32'h2,        32'h7FFFFFFC, 34};
      vecs[7]  = '{0, 3'b111, 32'hFFFFFFF9, 32'h2,        32'h1,        34};
      vecs[8]  = '{0, 3'b100, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
      vecs[9]  = '{0, 3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 34};
      vecs[10] = '{0, 3'b100, 32'h5,        32'h0,        32'hFFFFFFFF, 1};
      vecs[11] = '{0, 3'b111, 32'h5,        32'h0,        32'h5,        1};
      vecs[12] = '{0, 3'b101, 32'h5,        32'h0,        32'hFFFFFFFF, 1};
      vecs[13] = '{0, 3'b110, 32'h7,        32'h0,        32'h7,        1};
      vecs[14] = '{0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[15] = '{0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
      vecs[16] = '{1, 3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
      vecs[17] = '{1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
      vecs[18] = '{1, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
      vecs[19] = '{1, 3'b010, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 34};
      vecs[20] = '{2, 3'b100, 32'd1000,     32'd3,        32'd333,      10};
      vecs[21] = '{2, 3'b110, 32'hFFFFFC18, 32'd3,        32'hFFFFFFFF, 10};
      vecs[22] = '{2, 3'b100, 32'hFFFFFC18, 32'd3,        32'hFFFFFEB3, 10};
      vecs[23] = '{2, 3'b000, 32'h12345678, 32'h10,       32'h23456780, 10};
      vecs[24] = '{2, 3'b011, 32'h12345678, 32'h10,       32'h1,        10};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset hold u%0d", k),   {31'b0, hold[k]},  32'd0);
         check($sformatf("reset valid u%0d", k),  {31'b0, valid[k]}, 32'd0);
         check($sformatf("reset result u%0d", k), res[k],            32'd0);
      end
      reset = 1'b0;

      // Directed vector table, issued back-to-back per unit
      for (int i = 0; i < NV; i++)
         run_op(vecs[i].dut, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                $sformatf("v%0d_u%0d_%s", i, vecs[i].dut, opn[vecs[i].op]));

      // Flush at CALC cycle 10, then a full-latency DIVU right behind it
      op = 3'b101; a = 32'd100; b = 32'd7; start[0] = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; start[0] = 1'b0;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush hold",  {31'b0, hold[0]},  32'd0);
      check("flush valid", {31'b0, valid[0]}, 32'd0);
      run_op(0, 3'b101, 32'd100, 32'd7, 32'd14, 34, "after_flush_divu");

      // Flush together with start in IDLE: nothing accepted
      op = 3'b101; a = 32'd100; b = 32'd7; start[0] = 1'b1; flush = 1'b1;
      #1;
      check("flush+start hold", {31'b0, hold[0]}, 32'd0);
      @(posedge clk); @(negedge clk);
      start[0] = 1'b0; flush = 1'b0;
      #1;
      check("flush+start not busy", {31'b0, hold[0]}, 32'd0);

      // Stall in DONE for 3 cycles, release one edge after stall falls
      @(negedge clk);
      stall = 1'b1; op = 3'b100; a = 32'd5; b = 32'd0; start[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      start[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall valid c%0d", i),  {31'b0, valid[0]}, 32'd1);
         check($sformatf("stall result c%0d", i), res[0],            32'hFFFFFFFF);
         check($sformatf("stall hold c%0d", i),   {31'b0, hold[0]},  32'd0);
         if (i < 2) begin
            @(posedge clk); @(negedge clk);
         end
      end
      stall = 1'b0;
      @(posedge clk); @(negedge clk);
      check("stall release valid", {31'b0, valid[0]}, 32'd0);

      // Flush beats a stalled DONE
      stall = 1'b1; op = 3'b111; a = 32'd9; b = 32'd0; start[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      start[0] = 1'b0;
      check("stall+flush pre valid",  {31'b0, valid[0]}, 32'd1);
      check("stall+flush pre result", res[0],            32'd9);
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      check("stall+flush valid", {31'b0, valid[0]}, 32'd0);
      stall = 1'b0;
      @(posedge clk); @(negedge clk);
      check("stall+flush stays idle", {31'b0, valid[0]}, 32'd0);

      // Reset in the middle of an iterative multiply, then a normal op
      op = 3'b000; a = 32'd7; b = 32'd3; start[1] = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1; start[1] = 1'b0;
      @(posedge clk); @(negedge clk);
      check("midcalc reset hold",   {31'b0, hold[1]},  32'd0);
      check("midcalc reset valid",  {31'b0, valid[1]}, 32'd0);
      check("midcalc reset result", res[1],            32'd0);
      reset = 1'b0;
      run_op(1, 3'b100, 32'd1000, 32'd3, 32'd333, 34, "post_reset_div");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
